conv_mem_responder: RTL and testbench

- Memory-side responder for the accelerator memory handshake (mem_operation / addr / data / mem_opdone) used by the matrix convolution and related compute blocks.
- Holds a word-addressed scratchpad with a programmable response latency.
- Provides a host port so firmware can preload parameters and operands and read back results while the accelerator is idle.

---
 rtl/conv_mem_responder.sv | 142 ++++++++++++++
 tb/tb_conv_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | conv_mem_responder: latency-programmable scratchpad behind the accelerator  |
// | mem_operation/mem_opdone handshake, plus an idle-time host port. Rev 1.0    |
// +-----------------------------------------------------------------------------+
module conv_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_operation,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  mem_opdone,
  input  logic                  host_en,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata,
  output logic                  host_ack,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           access_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [1:0] c_OP_READ  = 2'b01;
  localparam logic [1:0] c_OP_WRITE = 2'b11;
  localparam logic [1:0] c_OP_RSVD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_op;
  logic [31:0]           r_addr;
  logic [31:0]           r_data;
  logic [3:0]            r_lat;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_data_o;
  logic                  r_opdone;
  logic [31:0]           r_host_rdata;
  logic                  r_host_ack;
  logic                  r_err;
  logic [15:0]           r_access_cnt;

  logic                  w_acc_req;
  logic                  w_host_go;
  logic                  w_fire;
  logic                  w_oor;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_acc_req = (mem_operation != 2'b00);
  // Accelerator wins over a simultaneous host request.
  assign w_host_go = (r_state == IDLE) && !w_acc_req && host_en;
  assign w_fire    = (r_state == BUSY) && (r_lat == 4'd0);
  assign w_oor     = |r_addr[31:ADDR_WIDTH];
  assign w_idx     = r_addr[ADDR_WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc_req) w_state_nxt = BUSY;
      BUSY:    if (r_lat == 4'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scratchpad survives reset; gating on reset abandons an in-flight write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fire && (r_op == c_OP_WRITE) && !w_oor) begin
        r_mem[w_idx] <= r_data;
      end else if (w_host_go && host_we) begin
        r_mem[host_addr] <= host_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= 2'b00;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_lat        <= 4'd0;
      r_data_o     <= 32'd0;
      r_opdone     <= 1'b0;
      r_host_rdata <= 32'd0;
      r_host_ack   <= 1'b0;
      r_err        <= 1'b0;
      r_access_cnt <= 16'd0;
    end else begin
      r_opdone   <= w_fire;
      r_host_ack <= w_host_go;
      if ((r_state == IDLE) && w_acc_req) begin
        r_op   <= mem_operation;
        r_addr <= addr_i;
        r_data <= data_i;
        r_lat  <= 4'(LATENCY - 1);
      end else if ((r_state == BUSY) && (r_lat != 4'd0)) begin
        r_lat <= r_lat - 4'd1;
      end
      if (w_fire) begin
        r_access_cnt <= r_access_cnt + 16'd1;
        if (r_op == c_OP_READ) begin
          r_data_o <= w_oor ? 32'd0 : r_mem[w_idx];
        end
        if (w_oor || (r_op == c_OP_RSVD)) begin
          r_err <= 1'b1;
        end
      end
      if (w_host_go && !host_we) begin
        r_host_rdata <= r_mem[host_addr];
      end
    end
  end

  assign data_o     = r_data_o;
  assign mem_opdone = r_opdone;
  assign host_rdata = r_host_rdata;
  assign host_ack   = r_host_ack;
  assign busy       = (r_state != IDLE);
  assign err        = r_err;
  assign access_cnt = r_access_cnt;

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
`default_nettype none
// Directed plus randomized bench for conv_mem_responder against an array-based reference model.
module tb_conv_mem_responder;

  localparam int AW  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_operation;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        mem_opdone;
  logic        host_en;
  logic        host_we;
  logic [AW-1:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic        busy;
  logic        err;
  logic [15:0] access_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [2**AW];
  logic [15:0] model_cnt;
  logic        model_err;
  logic [31:0] model_dout;

  conv_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_operation(mem_operation), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .mem_opdone(mem_opdone), .host_en(host_en),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .busy(busy), .err(err),
    .access_cnt(access_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_o"}, data_o, 32'd0);
    chk({tag, "_opdone"}, 32'(mem_opdone), 32'd0);
    chk({tag, "_host_rdata"}, host_rdata, 32'd0);
    chk({tag, "_host_ack"}, 32'(host_ack), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_access_cnt"}, 32'(access_cnt), 32'd0);
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
    @(negedge clk);
    host_en = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    @(posedge clk); #1;
    chk("host_ack", 32'(host_ack), 32'd1);
    if (we) model_mem[a] = wd;
    else    chk("host_rdata", host_rdata, model_mem[a]);
    host_en = 1'b0;
  endtask

  // One accelerator access; inputs are scrambled during the wait to prove capture.
  task automatic acc_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic oor;
    @(negedge clk);
    mem_operation = op; addr_i = a; data_i = d;
    @(posedge clk); #1;
    mem_operation = 2'b00; addr_i = $urandom; data_i = $urandom;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!mem_opdone && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("opdone_latency", n, LAT);
    oor = (a >= 32'(2**AW));
    if (op == 2'b01) model_dout = oor ? 32'd0 : model_mem[a[AW-1:0]];
    else if (op == 2'b11 && !oor) model_mem[a[AW-1:0]] = d;
    if (oor || op == 2'b10) model_err = 1'b1;
    model_cnt = model_cnt + 16'd1;
    chk("data_o", data_o, model_dout);
    chk("access_cnt", 32'(access_cnt), 32'(model_cnt));
    chk("err", 32'(err), 32'(model_err));
    @(posedge clk); #1;
    chk("opdone_one_cycle", 32'(mem_opdone), 32'd0);
    chk("back_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int opd_at;
    int ack_at;
    logic [31:0] a;
    reset = 1'b1; mem_operation = 2'b00; addr_i = 32'd0; data_i = 32'd0;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 32'd0;
    model_cnt = 16'd0; model_err = 1'b0; model_dout = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 2**AW; i++) host_op(1'b1, AW'(i), $urandom);
    host_op(1'b1, 8'd0, 32'd5); host_op(1'b1, 8'd1, 32'd5);
    host_op(1'b1, 8'd2, 32'd3); host_op(1'b1, 8'd3, 32'd3);
    host_op(1'b1, 8'd7, 32'h77);

    // Held read opcode, address stepped on each opdone.
    @(negedge clk); mem_operation = 2'b01; addr_i = 32'd0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!mem_opdone && n < 20);
      chk("stream_gap", n, (i == 0) ? LAT + 1 : LAT + 2);
      model_dout = model_mem[i];
      model_cnt  = model_cnt + 16'd1;
      chk("stream_data", data_o, model_dout);
      if (i < 3) addr_i = 32'(i + 1);
      else       mem_operation = 2'b00;
    end
    @(posedge clk); #1;
    chk("stream_cnt", 32'(access_cnt), 32'd4);

    acc_op(2'b11, 32'h40, 32'hDEADBEEF);
    host_op(1'b0, 8'h40, 32'd0);
    chk("deadbeef", host_rdata, 32'hDEADBEEF);

    // Simultaneous host and accelerator request.
    @(negedge clk);
    mem_operation = 2'b01; addr_i = 32'h10; host_en = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    opd_at = -1; ack_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) mem_operation = 2'b00;
      if (mem_opdone && opd_at < 0) opd_at = k;
      if (host_ack && ack_at < 0) begin
        ack_at = k;
        host_en = 1'b0;
        chk("prio_host_rdata", host_rdata, model_mem[8'h20]);
      end
    end
    model_dout = model_mem[8'h10];
    model_cnt  = model_cnt + 16'd1;
    chk("prio_opdone_at", opd_at, LAT);
    chk("prio_ack_at", ack_at, LAT + 2);
    chk("prio_data_o", data_o, model_dout);

    // Out-of-range read and reserved opcode.
    chk("err_clear_before", 32'(err), 32'd0);
    acc_op(2'b01, 32'h100, 32'd0);
    acc_op(2'b10, 32'h5, 32'h1234);
    host_op(1'b0, 8'h05, 32'd0);
    acc_op(2'b11, 32'h8000_0003, 32'hBAD);
    host_op(1'b0, 8'h03, 32'd0);

    // Reset in the middle of a write to address 7.
    @(negedge clk); mem_operation = 2'b11; addr_i = 32'd7; data_i = 32'd9;
    @(posedge clk); #1;
    mem_operation = 2'b00; reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("reset_no_opdone", 32'(mem_opdone), 32'd0);
    end
    chk_all_zero("midreset");
    @(negedge clk); reset = 1'b0;
    model_cnt = 16'd0; model_err = 1'b0; model_dout = 32'd0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("post_reset_no_opdone", 32'(mem_opdone), 32'd0);
    host_op(1'b0, 8'd7, 32'd0);

    // Counter wrap from a preset near the top.
    @(negedge clk); force dut.r_access_cnt = 16'hFFFE;
    @(negedge clk); release dut.r_access_cnt;
    model_cnt = 16'hFFFE;
    acc_op(2'b01, 32'd1, 32'd0);
    chk("cnt_ffff", 32'(access_cnt), 32'h0000FFFF);
    acc_op(2'b01, 32'd2, 32'd0);
    chk("cnt_wrap", 32'(access_cnt), 32'd0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: host_op(1'b1, AW'($urandom), $urandom);
        1: host_op(1'b0, AW'($urandom), 32'd0);
        2: acc_op(2'b01, 32'($urandom_range(0, 2**AW - 1)), $urandom);
        3: acc_op(2'b11, 32'($urandom_range(0, 2**AW - 1)), $urandom);
        default: begin
          a = {24'($urandom_range(1, 32'h00FF_FFFF)), 8'($urandom)};
          case ($urandom_range(0, 2))
            0:       acc_op(2'b01, a, $urandom);
            1:       acc_op(2'b11, a, $urandom);
            default: acc_op(2'b10, 32'($urandom_range(0, 2**AW - 1)), $urandom);
          endcase
        end
      endcase
    end
    for (int i = 0; i < 8; i++) host_op(1'b0, AW'(i * 31), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
